// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - framebuffer arbiter bus: CPU port, scan-out port, memory port
//
// Groups the three handshake/bus bundles seen by fb_arbiter.
//   master : the environment (CPU load/store path, scan-out fetcher, ram64k)
//   slave  : the arbiter itself
// CPU    : cpu_req/cpu_wen/cpu_addr/cpu_wdata/cpu_wstrb in, cpu_gnt/cpu_rdata/cpu_rvalid out
// Scan   : scan_req/scan_urgent/scan_addr in, scan_gnt/scan_rdata/scan_rvalid out
// Memory : mem_wen/mem_addr/mem_wdata/mem_wstrb out, mem_rdata in (combinational from mem_addr)

interface fb_arbiter_if;
  // CPU load/store path
  logic        cpu_req;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  // Display scan-out fetcher (read only)
  logic        scan_req;
  logic        scan_urgent;
  logic [31:0] scan_addr;
  logic        scan_gnt;
  logic [31:0] scan_rdata;
  logic        scan_rvalid;

  // Single-port framebuffer memory
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output scan_req, scan_urgent, scan_addr,
    input  scan_gnt, scan_rdata, scan_rvalid,
    input  mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  scan_req, scan_urgent, scan_addr,
    output scan_gnt, scan_rdata, scan_rvalid,
    output mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - two-port arbiter sharing the VGA framebuffer between CPU and scan-out
//
// Ports:
//   clk             : single clock, all state on the rising edge
//   reset           : asynchronous active-low reset, synchronous release
//   bus             : fb_arbiter_if.slave (CPU, scan-out and memory bundles)
//   stat_cpu_stall  : cycles with cpu_req && !cpu_gnt (saturating, 16 bit)
//   stat_scan_stall : cycles with scan_req && !scan_gnt (saturating, 16 bit)
// Parameter:
//   MAX_WAIT        : CPU stall cycles before the CPU gains absolute priority (1..15)
// Optional feature macro:
//   FB_ARB_STATS_EN : builds the stall counters; otherwise both stat outputs read 0

module fb_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  fb_arbiter_if.slave  bus,
  output logic [15:0]  stat_cpu_stall,
  output logic [15:0]  stat_scan_stall
);

  typedef enum logic {
    WIN_CPU  = 1'b0,
    WIN_SCAN = 1'b1
  } win_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  // Registered state
  win_e        last_win_q, last_win_d;
  logic [3:0]  cpu_wait_q, cpu_wait_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic [31:0] scan_rdata_q, scan_rdata_d;
  logic        scan_rvalid_q, scan_rvalid_d;

  // Combinational grant decision
  logic cpu_win;
  logic scan_win;
  logic cpu_escalated;

  assign cpu_escalated = bus.cpu_req && (cpu_wait_q >= MaxWait);

  // Grant priority: escalated CPU, urgent scan, round-robin tie, single requester.
  // Reset gates the grants so nothing reaches memory while reset is asserted.
  always_comb begin
    cpu_win  = 1'b0;
    scan_win = 1'b0;
    if (!reset) begin
      cpu_win  = 1'b0;
      scan_win = 1'b0;
    end else if (cpu_escalated) begin
      cpu_win = 1'b1;
    end else if (bus.scan_req && bus.scan_urgent) begin
      scan_win = 1'b1;
    end else if (bus.cpu_req && bus.scan_req) begin
      if (last_win_q == WIN_SCAN) begin
        cpu_win = 1'b1;
      end else begin
        scan_win = 1'b1;
      end
    end else if (bus.cpu_req) begin
      cpu_win = 1'b1;
    end else if (bus.scan_req) begin
      scan_win = 1'b1;
    end
  end

  // Memory port mux; scan-out is read only so it never drives write enables
  always_comb begin
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    if (cpu_win) begin
      bus.mem_wen   = bus.cpu_wen;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_wstrb = bus.cpu_wstrb;
    end else if (scan_win) begin
      bus.mem_addr  = bus.scan_addr;
    end
  end

  // Next-state logic
  always_comb begin
    last_win_d    = last_win_q;
    cpu_wait_d    = 4'h0;
    cpu_rvalid_d  = 1'b0;
    scan_rvalid_d = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    scan_rdata_d  = scan_rdata_q;

    if (cpu_win) begin
      last_win_d = WIN_CPU;
    end else if (scan_win) begin
      last_win_d = WIN_SCAN;
    end

    // Stall counter saturates at 15 so it can never wrap below MAX_WAIT
    if (bus.cpu_req && !cpu_win) begin
      cpu_wait_d = (cpu_wait_q == 4'hF) ? 4'hF : cpu_wait_q + 4'h1;
    end

    if (cpu_win && !bus.cpu_wen) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = bus.mem_rdata;
    end

    if (scan_win) begin
      scan_rvalid_d = 1'b1;
      scan_rdata_d  = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_win_q    <= WIN_SCAN;
      cpu_wait_q    <= 4'h0;
      cpu_rdata_q   <= 32'h0;
      cpu_rvalid_q  <= 1'b0;
      scan_rdata_q  <= 32'h0;
      scan_rvalid_q <= 1'b0;
    end else begin
      last_win_q    <= last_win_d;
      cpu_wait_q    <= cpu_wait_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      scan_rdata_q  <= scan_rdata_d;
      scan_rvalid_q <= scan_rvalid_d;
    end
  end

  assign bus.cpu_gnt     = cpu_win;
  assign bus.scan_gnt    = scan_win;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.scan_rdata  = scan_rdata_q;
  assign bus.scan_rvalid = scan_rvalid_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_cpu_q, stat_cpu_d;
  logic [15:0] stat_scan_q, stat_scan_d;

  always_comb begin
    stat_cpu_d  = stat_cpu_q;
    stat_scan_d = stat_scan_q;
    if (bus.cpu_req && !cpu_win && (stat_cpu_q != 16'hFFFF)) begin
      stat_cpu_d = stat_cpu_q + 16'h1;
    end
    if (bus.scan_req && !scan_win && (stat_scan_q != 16'hFFFF)) begin
      stat_scan_d = stat_scan_q + 16'h1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cpu_q  <= 16'h0;
      stat_scan_q <= 16'h0;
    end else begin
      stat_cpu_q  <= stat_cpu_d;
      stat_scan_q <= stat_scan_d;
    end
  end

  assign stat_cpu_stall  = stat_cpu_q;
  assign stat_scan_stall = stat_scan_q;
`else
  assign stat_cpu_stall  = 16'h0;
  assign stat_scan_stall = 16'h0;
`endif

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Two-port arbiter sharing the single-port VGA framebuffer memory (`ram64k` instance) between the CPU load/store path and the display scan-out fetcher. Grants at most one access per cycle: round-robin on contention, scan-out priority when urgent, and an anti-starvation escalation that bounds CPU wait. Returns registered read data to the winning requester one cycle after grant.

## Interface
- `MAX_WAIT`, default 4. Consecutive CPU stall cycles before the CPU gains absolute priority. Legal range 1..15.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0); deassertion synchronous to `clk`.
- `cpu_req` in 1: CPU access request.
- `cpu_wen` in 1: 1 = write, 0 = read.
- `cpu_addr` in 32: framebuffer byte address (offset already removed).
- `cpu_wdata` in 32: write data.
- `cpu_wstrb` in 4: byte enables.
- `cpu_gnt` out 1: CPU access performed this cycle.
- `cpu_rdata` out 32: registered read data.
- `cpu_rvalid` out 1: `cpu_rdata` valid (one-cycle pulse).
- `scan_req` in 1: scan-out read request.
- `scan_urgent` in 1: scan-out FIFO below low-water mark.
- `scan_addr` in 32: scan-out read address.
- `scan_gnt` out 1: scan read performed this cycle.
- `scan_rdata` out 32: registered read data.
- `scan_rvalid` out 1: `scan_rdata` valid (one-cycle pulse).
- `mem_wen` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: framebuffer port.
- `mem_rdata` in 32: framebuffer read data, combinational from `mem_addr`.
- `stat_cpu_stall` out 16, `stat_scan_stall` out 16: statistics (see Configuration).

## Operation
- State: `last_win` (0 = CPU, 1 = SCAN), `cpu_wait` (4-bit, saturating at 15), read-return registers, optional stat counters.
- Grant priority, evaluated combinationally each cycle:
  1. `cpu_req && cpu_wait >= MAX_WAIT` -> CPU.
  2. `scan_req && scan_urgent` -> SCAN.
  3. Both requesting -> the requester not equal to `last_win`.
  4. Single requester -> that requester.
  5. None -> no grant.
- The winner drives the `mem_*` port in the same cycle. With no grant, all `mem_*` outputs are 0. A scan grant always drives `mem_wen`=0 and `mem_wstrb`=0.
- `last_win` updates on any grant.
- `cpu_wait`:
  - +1 each cycle with `cpu_req && !cpu_gnt`.
  - Cleared on `cpu_gnt` or `!cpu_req`.
- On a read grant, `mem_rdata` is captured into `<winner>_rdata`, and `<winner>_rvalid` = 1 in the next cycle only. Writes produce no rvalid.
- Requester rule: `req` and its address/data stay stable until `gnt`. Dropping `req` before `gnt` withdraws the request and produces no access.
- Simultaneous CPU escalation and scan urgency: the CPU wins (rule 1 precedes rule 2).
- Back-to-back grants to the same requester are legal. Each read yields its own rvalid pulse in the following cycle.

## Timing
- Grant latency: 0 cycles, since `gnt` is combinational in the request cycle.
- Read data latency: 1 cycle after `gnt`.
- Throughput: one access per cycle in total.
- Worst-case CPU wait: `MAX_WAIT` cycles with continuous urgent scan traffic.
- Reset values:
  - `cpu_rdata`, `scan_rdata` = 0; `cpu_rvalid`, `scan_rvalid` = 0.
  - `last_win` = SCAN, so the CPU wins the first tie.
  - `cpu_wait` = 0; stat counters = 0.
  - `gnt` and `mem_*` outputs are 0 while reset is asserted.
- Reset asserted mid-transaction: a pending rvalid is dropped and the grant is not retried. Requesters must re-request after release.

## Configuration
- `FB_ARB_STATS_EN` defined:
  - `stat_cpu_stall` counts cycles with `cpu_req && !cpu_gnt`.
  - `stat_scan_stall` counts cycles with `scan_req && !scan_gnt`.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared only by reset.
- Not defined: both stat outputs are tied to 0 and no counter flops are built. The port list is unchanged.

## Test plan
- Only `cpu_req` active, read at 0x0000_0100 with `mem_rdata` 0xDEADBEEF -> `cpu_gnt`=1 that cycle, `mem_addr`=0x100; next cycle `cpu_rvalid`=1, `cpu_rdata`=0xDEADBEEF.
- First cycle after reset, CPU write (0x40, 0x12345678, strb 0xF) and scan read both request, non-urgent -> CPU granted, `mem_wen`=1. Next cycle, with both still requesting, SCAN is granted (round-robin).
- `scan_req` and `scan_urgent` held high continuously, `cpu_req` high, `MAX_WAIT`=4 -> SCAN granted for 4 cycles, CPU granted in the 5th, `cpu_wait` returns to 0.
- SB-style write, `cpu_wstrb`=0x1 at 0x3 with scan idle -> `mem_wstrb`=0x1, `mem_addr`=0x3; no `cpu_rvalid` follows.
- Scan read granted, then `reset`=0 in the following cycle -> `scan_rvalid` stays 0; all outputs at reset values until release.
- `FB_ARB_STATS_EN` defined, CPU stalled 3 cycles behind urgent scan -> `stat_cpu_stall`=3. Without the macro -> `stat_cpu_stall`=0.
